// File: rtl/gate_sweep_unit_pkg.sv
// Shared constants for gate_sweep_unit: gate op codes, FSM encoding and
// the ones_count width helper.
package gate_sweep_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // A full sweep can see all 2^n patterns evaluate to 1, so one extra bit.
   function automatic int ones_width(input int n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/gate_sweep_unit_gate_eval.sv
// Combinational N-input gate evaluator; reserved op codes yield 0.
module gate_eval
   import gate_sweep_unit_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0] operand,
   input  logic [2:0]      op,
   output logic            result
);

   always_comb begin
      result = 1'b0;
      case (op)
         OP_AND:  result = &operand;
         OP_OR:   result = |operand;
         OP_XOR:  result = ^operand;
         OP_NAND: result = ~&operand;
         OP_NOR:  result = ~|operand;
         OP_XNOR: result = ~^operand;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_unit.sv
// Gate evaluator with a direct operand mode and an exhaustive truth-table
// sweep mode that holds each pattern for DWELL cycles and counts ones.
module gate_sweep_unit
   import gate_sweep_unit_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int DWELL = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [2:0]                       op_sel,
   input  logic [N_IN-1:0]                  in_vec,
   input  logic                             in_valid,
   input  logic                             start,
   output logic                             y,
   output logic                             out_valid,
   output logic [N_IN-1:0]                  pattern,
   output logic                             busy,
   output logic                             done,
   output logic [ones_width(N_IN)-1:0]      ones_count
);

   localparam int              CW         = ones_width(N_IN);
   localparam logic [N_IN-1:0] LAST_PAT   = {N_IN{1'b1}};
   localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);

   state_t          state_reg, state_next;
   logic [2:0]      op_reg, op_next;
   logic [N_IN-1:0] pat_cnt_reg, pat_cnt_next;
   logic [7:0]      dwell_reg, dwell_next;
   logic            y_reg, y_next;
   logic            ov_reg, ov_next;
   logic [N_IN-1:0] pattern_reg, pattern_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic [CW-1:0]   ones_reg, ones_next;

   logic [N_IN-1:0] eval_operand;
   logic [2:0]      eval_op;
   logic            eval_result;

   // One evaluator serves both modes; the sweep feeds it the counter and latched op.
   assign eval_operand = (state_reg == ST_SWEEP) ? pat_cnt_reg : in_vec;
   assign eval_op      = (state_reg == ST_SWEEP) ? op_reg      : op_sel;

   gate_eval #(.N_IN(N_IN)) u_gate_eval (
      .operand (eval_operand),
      .op      (eval_op),
      .result  (eval_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         op_reg      <= '0;
         pat_cnt_reg <= '0;
         dwell_reg   <= '0;
         y_reg       <= 1'b0;
         ov_reg      <= 1'b0;
         pattern_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ones_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         pat_cnt_reg <= pat_cnt_next;
         dwell_reg   <= dwell_next;
         y_reg       <= y_next;
         ov_reg      <= ov_next;
         pattern_reg <= pattern_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         ones_reg    <= ones_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      pat_cnt_next = pat_cnt_reg;
      dwell_next   = dwell_reg;
      y_next       = y_reg;
      ov_next      = 1'b0;
      pattern_next = pattern_reg;
      done_next    = 1'b0;
      ones_next    = ones_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next   = ST_SWEEP;
               op_next      = op_sel;
               ones_next    = '0;
               pat_cnt_next = '0;
               dwell_next   = '0;
            end else if (in_valid) begin
               y_next       = eval_result;
               pattern_next = in_vec;
               ov_next      = 1'b1;
            end
         end
         ST_SWEEP: begin
            y_next       = eval_result;
            pattern_next = pat_cnt_reg;
            // First dwell cycle of a pattern: flag it and count it exactly once.
            if (dwell_reg == 8'd0) begin
               ov_next = 1'b1;
               if (eval_result) ones_next = ones_reg + CW'(1);
            end
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               if (pat_cnt_reg == LAST_PAT) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
               end else begin
                  pat_cnt_next = pat_cnt_reg + N_IN'(1);
               end
            end else begin
               dwell_next = dwell_reg + 8'd1;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   assign y          = y_reg;
   assign out_valid  = ov_reg;
   assign pattern    = pattern_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign ones_count = ones_reg;

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Randomized bench for gate_sweep_unit against a time-offset behavioural model,
// plus literal expectations for the documented scenarios.
module tb_gate_sweep_unit;

   localparam int N  = 2;
   localparam int DW = 4;
   localparam int P  = 1 << N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   op_sel = 3'd0;
   logic [N-1:0] in_vec = '0;
   logic         in_valid = 1'b0;
   logic         start = 1'b0;
   logic         y, out_valid, busy, done;
   logic [N-1:0] pattern;
   logic [N:0]   ones_count;

   logic [2:0]   in_vec3 = 3'd0;
   logic         y3, ov3, busy3, done3;
   logic [2:0]   pattern3;
   logic [3:0]   ones3;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   gate_sweep_unit #(.N_IN(N), .DWELL(DW)) dut (
      .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .in_vec(in_vec),
      .in_valid(in_valid), .start(start), .y(y), .out_valid(out_valid),
      .pattern(pattern), .busy(busy), .done(done), .ones_count(ones_count)
   );

   gate_sweep_unit #(.N_IN(3), .DWELL(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .in_vec(in_vec3),
      .in_valid(in_valid), .start(start), .y(y3), .out_valid(ov3),
      .pattern(pattern3), .busy(busy3), .done(done3), .ones_count(ones3)
   );

   // Gate truth from the population count of the operand.
   function automatic logic ref_gate(input logic [2:0] op, input int v, input int n);
      int pc = 0;
      for (int i = 0; i < n; i++) pc += (v >> i) & 1;
      case (op)
         3'd0:    return pc == n;
         3'd1:    return pc > 0;
         3'd2:    return (pc % 2) == 1;
         3'd3:    return pc != n;
         3'd4:    return pc == 0;
         3'd5:    return (pc % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int prefix_ones(input logic [2:0] op, input int p);
      int c = 0;
      for (int q = 0; q <= p; q++) c += int'(ref_gate(op, q, N));
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outputs derived from the number of edges since the start edge.
   bit         m_sweep;
   int         m_k;
   logic [2:0] m_op;
   logic       m_y, m_ov, m_busy, m_done;
   int         m_pat, m_ones;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sweep <= 1'b0; m_k <= 0; m_op <= '0; m_y <= 1'b0; m_ov <= 1'b0;
         m_busy <= 1'b0; m_done <= 1'b0; m_pat <= 0; m_ones <= 0;
      end else if (!m_sweep) begin
         m_done <= 1'b0;
         if (start) begin
            m_sweep <= 1'b1; m_k <= 0; m_op <= op_sel; m_ones <= 0;
            m_ov <= 1'b0; m_busy <= 1'b1;
         end else begin
            m_busy <= 1'b0;
            m_ov   <= in_valid;
            if (in_valid) begin
               m_y   <= ref_gate(op_sel, int'(in_vec), N);
               m_pat <= int'(in_vec);
            end
         end
      end else begin
         m_k <= m_k + 1;
         if (m_k < P * DW) begin
            m_y    <= ref_gate(m_op, m_k / DW, N);
            m_pat  <= m_k / DW;
            m_ov   <= (m_k % DW) == 0;
            m_ones <= prefix_ones(m_op, m_k / DW);
            m_done <= (m_k + 1) == P * DW;
            m_busy <= 1'b1;
         end else begin
            m_sweep <= 1'b0; m_done <= 1'b0; m_busy <= 1'b0; m_ov <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("y", y, m_y);
         chk("out_valid", out_valid, m_ov);
         chk("pattern", pattern, m_pat);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("ones_count", ones_count, m_ones);
      end
   end

   logic [3:0] last_ones3 = '0;
   bit         y3_hi = 1'b0;
   bit         y3_clr = 1'b0;
   always @(negedge clk) begin
      if (done3) last_ones3 <= ones3;
      if (y3_clr) y3_hi <= 1'b0;
      else if (busy3 && y3) y3_hi <= 1'b1;
   end

   task automatic pulse_start(input logic [2:0] op);
      op_sel = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge after the start edge (cycle 1); returns once idle.
   task automatic wait_idle(input int max_cyc, input bit noise,
                            output int done_cyc, output int n_ov, output int n_done);
      int cyc = 1;
      done_cyc = -1; n_ov = 0; n_done = 0;
      while (busy && cyc <= max_cyc) begin
         if (out_valid) n_ov++;
         if (done) begin n_done++; done_cyc = cyc; end
         if (noise && !done) begin
            start = 1'($urandom); in_valid = 1'($urandom);
            op_sel = 3'($urandom); in_vec = N'($urandom);
         end else begin
            start = 1'b0; in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; in_valid = 1'b0;
      chk("sweep_ends", busy, 0);
      $display("sweep ones=%0d done_cycle=%0d pulses=%0d", ones_count, done_cyc, n_ov);
   endtask

   initial begin
      int dc, nov, nd;
      logic [2:0] rop;

      repeat (3) @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ones", ones_count, 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Direct AND
      op_sel = 3'd0; in_vec = 2'b11; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("dir_and11_y", y, 1); chk("dir_and11_ov", out_valid, 1); chk("dir_and11_pat", pattern, 3);
      $display("direct op=0 in=3 y=%0d", y);
      in_vec = 2'b01; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("dir_and01_y", y, 0); chk("dir_and01_ov", out_valid, 1);
      $display("direct op=0 in=1 y=%0d", y);
      @(negedge clk);
      chk("dir_ov_drop", out_valid, 0);

      // Random direct traffic
      for (int i = 0; i < 40; i++) begin
         op_sel = 3'($urandom); in_vec = N'($urandom); in_valid = 1'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);

      // XOR sweep
      pulse_start(3'd2);
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("xor_done_cycle", dc, 17); chk("xor_pulses", nov, 4);
      chk("xor_ones", ones_count, 2); chk("xor_done_count", nd, 1);
      repeat (3) @(negedge clk);
      chk("xor_ones_hold", ones_count, 2);

      // NAND sweep: N=2 gives 3, N=3 gives 7
      pulse_start(3'd3);
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("nand_ones", ones_count, 3);
      chk("nand3_ones", last_ones3, 7);

      // Reserved op
      y3_clr = 1'b1; @(negedge clk); y3_clr = 1'b0;
      pulse_start(3'd6);
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("op6_ones", ones_count, 0);
      chk("op6_ones3", last_ones3, 0);
      chk("op6_y3_low", y3_hi, 0);

      // Collision: start with in_valid, then a start during the sweep
      op_sel = 3'd2; in_vec = 2'b11; in_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      chk("coll_no_direct", out_valid, 0);
      chk("coll_busy", busy, 1);
      fork
         begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join_none
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("coll_done_once", nd, 1);
      chk("coll_done_cycle", dc, 17);

      // op_sel change mid-sweep
      pulse_start(3'd2);
      repeat (5) @(negedge clk);
      op_sel = 3'd1;
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("opchg_ones", ones_count, 2);

      // Reset mid-sweep
      pulse_start(3'd2);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y", y, 0); chk("arst_ov", out_valid, 0); chk("arst_pat", pattern, 0);
      chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_ones", ones_count, 0);
      repeat (2) begin
         @(negedge clk);
         chk("arst_no_done", done, 0);
      end
      op_sel = 3'd2; start = 1'b1;
      #2 rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("arst_restart_busy", busy, 1);
      wait_idle(60, 1'b0, dc, nov, nd);
      chk("arst_restart_done", dc, 17);
      chk("arst_restart_ones", ones_count, 2);

      // Random sweeps with input noise during the sweep
      for (int r = 0; r < 12; r++) begin
         rop = 3'($urandom);
         in_valid = 1'($urandom); in_vec = N'($urandom);
         pulse_start(rop);
         in_valid = 1'b0;
         wait_idle(60, 1'b1, dc, nov, nd);
         chk("rnd_done_cycle", dc, 17);
         chk("rnd_pulses", nov, 4);
         chk("rnd_done_count", nd, 1);
         for (int i = 0; i < 6; i++) begin
            op_sel = 3'($urandom); in_vec = N'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b0;
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_sweep_unit.md
GATE_SWEEP_UNIT -- requirements
Module: gate_sweep_unit

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning gate input count (2..8).
REQ-002 SHALL have parameter DWELL, default 4, meaning clock cycles each sweep pattern is held (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port op_sel  input  3  gate op: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
REQ-006 SHALL have port in_vec  input  N_IN  operand vector, direct mode.
REQ-007 SHALL have port in_valid  input  1  in_vec/op_sel valid this cycle, direct mode.
REQ-008 SHALL have port start  input  1  one-cycle request to begin an exhaustive truth-table sweep.
REQ-009 SHALL have port y  output  1  registered gate result.
REQ-010 SHALL have port out_valid  output  1  y/pattern valid pulse.
REQ-011 SHALL have port pattern  output  N_IN  operand vector that produced y.
REQ-012 SHALL have port busy  output  1  high while a sweep runs.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-014 SHALL have port ones_count  output  N_IN+1  number of sweep patterns whose result was 1.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-016 In IDLE with in_valid=1 and start=0, SHALL register y=op(in_vec), pattern=in_vec, out_valid=1 on the next edge (latency 1); otherwise out_valid=0.
REQ-017 Reserved op codes SHALL produce y=0 in both modes.
REQ-018 In IDLE, start=1 SHALL latch op_sel, clear ones_count, load pattern counter 0, dwell counter 0, and enter SWEEP; start has priority over a simultaneous in_valid, which is dropped.
REQ-019 In SWEEP, each pattern value SHALL be held DWELL cycles; y and pattern SHALL update with 1-cycle latency; out_valid SHALL pulse only on the first output cycle of each pattern.
REQ-020 ones_count SHALL increment once per pattern whose result is 1, never per dwell cycle.
REQ-021 After pattern 2^N_IN-1 completes its dwell, FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-022 Pattern counter SHALL NOT wrap inside a sweep; ones_count SHALL hold its final value until the next start.
REQ-023 start, in_valid and op_sel changes SHALL be ignored in SWEEP and DONE.
REQ-024 busy SHALL be 1 in SWEEP and DONE, 0 in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, y=0, out_valid=0, pattern=0, busy=0, done=0, ones_count=0, all counters 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release the block SHALL accept a new start on the first edge.

Structure
REQ-027 A shared package SHALL hold op-code constants, FSM state encoding and the ones_count width function.
REQ-028 SHALL contain one combinational sub-module gate_eval (N_IN vector + op -> 1-bit result), instantiated once and shared by both modes.
REQ-029 SHALL contain no latches; all outputs registered.

Verification
REQ-030 Direct: N_IN=2, op=AND, in_vec=11, in_valid pulse -> next cycle y=1, out_valid=1, pattern=11; in_vec=01 -> y=0.
REQ-031 Sweep: N_IN=2, DWELL=4, op=XOR, start -> patterns 00,01,10,11 each 4 cycles, y=0,1,1,0, four out_valid pulses, done at cycle 17, ones_count=2.
REQ-032 Sweep: N_IN=3, op=NAND -> ones_count=7; op=6 -> ones_count=0, y constantly 0.
REQ-033 Collision: start and in_valid same cycle in IDLE -> sweep begins, no direct out_valid; start pulse during SWEEP -> no restart, done occurs once.
REQ-034 Reset: rst_n low at cycle 6 of a sweep -> all outputs 0 immediately, no done; new start after release -> full sweep completes correctly.
REQ-035 op_sel change mid-sweep (XOR->OR) -> results continue as XOR; ones_count=2 for N_IN=2.
